// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
package display_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_F     = 7'b1110001;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } scan_state_t;

endpackage

// File: rtl/display_scanner_decoder.sv
// Shared BCD-to-7-segment decoder (gfedcba, 1 = segment on); codes above 9 render 'F'.
module display_scanner_decoder
  import display_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_in,
  output logic [6:0]       segment_out
);

  always_comb begin
    // NOTE: a default on every path keeps combinational logic from inferring a latch.
    segment_out = SEG_F;
    case (bcd_in)
      4'd0: segment_out = 7'b0111111;
      4'd1: segment_out = 7'b0000110;
      4'd2: segment_out = 7'b1011011;
      4'd3: segment_out = 7'b1001111;
      4'd4: segment_out = 7'b1100110;
      4'd5: segment_out = 7'b1101101;
      4'd6: segment_out = 7'b1111101;
      4'd7: segment_out = 7'b0000111;
      4'd8: segment_out = 7'b1111111;
      4'd9: segment_out = 7'b1101111;
      default: segment_out = SEG_F;
    endcase
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed scanner driving NUM_DIGITS common-cathode digits from one shared decoder.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always shown).
module display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
  output logic [6:0]                  segment_out,
  output logic [NUM_DIGITS-1:0]       digit_sel,
  output logic                        frame_done
);

  localparam int TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int WW   = BCD_W * NUM_DIGITS;

  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  scan_state_t       state;
  logic [IW-1:0]     idx;
  logic [TW-1:0]     timer;
  logic [WW-1:0]     staging;
  logic [WW-1:0]     shadow;
  logic              pending;

  logic [BCD_W-1:0]  nibble;
  logic [6:0]        dec_seg;
  logic              blank_digit;
  logic              last_digit;
  logic [IW-1:0]     next_idx;
  logic              boundary;

  // idx/shadow feed the decoder a cycle ahead so the registered outputs line up with digit_sel.
  assign nibble     = shadow[int'(idx)*BCD_W +: BCD_W];
  assign last_digit = (idx == IDX_LAST);
  assign next_idx   = last_digit ? '0 : idx + IW'(1);

  display_scanner_decoder u_decoder (
    .bcd_in      (nibble),
    .segment_out (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    blank_digit = 1'b0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if ((int'(idx) == i) && ((shadow >> (i*BCD_W)) == '0)) blank_digit = 1'b1;
    end
  end
`else
  assign blank_digit = 1'b0;
`endif

  // The last digit's phase ends here: dwell end when there is no blank phase, else blank end.
  assign boundary = en && last_digit &&
                    (((state == BLANK) && (timer == BLANK_LAST)) ||
                     ((state == SHOW) && (BLANK_CYCLES == 0) && (timer == DWELL_LAST)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      timer       <= '0;
      segment_out <= SEG_BLANK;
      digit_sel   <= '0;
      frame_done  <= 1'b0;
      staging     <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      frame_done <= 1'b0;

      // Double buffer: the displayed word only changes on a frame boundary while scanning.
      if (state == IDLE) begin
        if (load) shadow <= bcd_in;
      end else if (boundary) begin
        if (pending) shadow <= staging;
        pending <= load;
        if (load) staging <= bcd_in;
      end else if (load) begin
        staging <= bcd_in;
        pending <= 1'b1;
      end

      if (!en) begin
        state       <= IDLE;
        idx         <= '0;
        timer       <= '0;
        digit_sel   <= '0;
        segment_out <= SEG_BLANK;
      end else begin
        case (state)
          IDLE: begin
            state       <= SHOW;
            idx         <= '0;
            timer       <= '0;
            digit_sel   <= '0;
            segment_out <= SEG_BLANK;
          end
          SHOW: begin
            digit_sel   <= NUM_DIGITS'(1) << idx;
            segment_out <= blank_digit ? SEG_BLANK : dec_seg;
            if (timer == DWELL_LAST) begin
              timer <= '0;
              if (BLANK_CYCLES > 0) begin
                state <= BLANK;
              end else begin
                idx        <= next_idx;
                frame_done <= last_digit;
              end
            end else begin
              timer <= timer + TW'(1);
            end
          end
          BLANK: begin
            digit_sel   <= '0;
            segment_out <= SEG_BLANK;
            if (timer == BLANK_LAST) begin
              timer      <= '0;
              state      <= SHOW;
              idx        <= next_idx;
              frame_done <= last_digit;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          default: begin
            state <= IDLE;
            idx   <= '0;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner (4 digits, dwell 4, blank 2, 24-cycle frame).
// Honours LEADING_ZERO_BLANK_EN in its reference model when the macro is defined.
module tb_display_scanner;

  localparam int N     = 4;
  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = DW + BL;
  localparam int FRAME = N * SLOT;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            load;
  logic [4*N-1:0]  bcd_in;
  logic [6:0]      segment_out;
  logic [N-1:0]    digit_sel;
  logic            frame_done;

  int checks   = 0;
  int failures = 0;

  // Reference model: position within the frame plus a displayed/staged word pair.
  bit              m_running;
  int              m_t;
  logic [4*N-1:0]  m_shown;
  logic [4*N-1:0]  m_staged;
  bit              m_pending;
  logic [N-1:0]    exp_sel;
  logic [6:0]      exp_seg;
  logic            exp_fd;

  always #5 clk = ~clk;

  display_scanner #(
    .NUM_DIGITS   (N),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load        (load),
    .bcd_in      (bcd_in),
    .segment_out (segment_out),
    .digit_sel   (digit_sel),
    .frame_done  (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [4*N-1:0] word, input int digit);
    logic [3:0] nib;
    nib = word[digit*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (digit != 0 && (word >> (digit*4)) == 0) return 7'b0000000;
`endif
    return (nib > 9) ? 7'b1110001 : SEG_TAB[nib];
  endfunction

  task automatic model_reset();
    m_running = 0;
    m_t       = 0;
    m_shown   = '0;
    m_staged  = '0;
    m_pending = 0;
    exp_sel   = '0;
    exp_seg   = '0;
    exp_fd    = 1'b0;
  endtask

  // One clock edge of the model, using the inputs the DUT samples at that edge.
  task automatic model_edge();
    int f;
    exp_sel = '0;
    exp_seg = '0;
    exp_fd  = 1'b0;
    if (!m_running) begin
      if (load) m_shown = bcd_in;
      if (en) begin
        m_running = 1;
        m_t       = 0;
      end
    end else if (!en) begin
      m_running = 0;
      if (load) begin
        m_staged  = bcd_in;
        m_pending = 1;
      end
    end else begin
      f = m_t % FRAME;
      if ((f % SLOT) < DW) begin
        exp_sel = N'(1) << (f / SLOT);
        exp_seg = seg_of(m_shown, f / SLOT);
      end
      if (f == FRAME - 1) begin
        exp_fd = 1'b1;
        if (m_pending) m_shown = m_staged;
        m_pending = 0;
      end
      if (load) begin
        m_staged  = bcd_in;
        m_pending = 1;
      end
      m_t++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("digit_sel", 32'(digit_sel), 32'(exp_sel));
    check("segment_out", 32'(segment_out), 32'(exp_seg));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    check("onehot", 32'($countones(digit_sel) <= 1), 32'd1);
    load = 1'b0;
  endtask

  // Advance until the next edge starts a new frame; bounded so a stuck model cannot hang the run.
  task automatic to_frame_start();
    int guard = 0;
    while ((m_t % FRAME) != 0 && guard < 2*FRAME) begin
      tick();
      guard++;
    end
    check("frame_align", 32'(m_t % FRAME), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; bcd_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_sel", 32'(digit_sel), 32'd0);
    check("rst_seg", 32'(segment_out), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);

    // Async reset in mid-SHOW, then release with en held high.
    rst = 1'b0; en = 1'b1;
    repeat (3) tick();
    check("pre_rst_lit", 32'(digit_sel), 32'b0001);
    #2 rst = 1'b1;
    #1;
    check("async_sel", 32'(digit_sel), 32'd0);
    check("async_seg", 32'(segment_out), 32'd0);
    check("async_fd", 32'(frame_done), 32'd0);
    model_reset();
    #2 rst = 1'b0;
    tick();
    check("release_dark", 32'(digit_sel), 32'd0);
    tick();
    check("release_lit", 32'(digit_sel), 32'b0001);

    // Load 1234 while idle, then scan a full frame.
    en = 1'b0;
    tick();
    load = 1'b1; bcd_in = 16'h1234;
    tick();
    en = 1'b1;
    tick();
    for (int j = 0; j < FRAME; j++) begin
      tick();
      if (j == 0)  begin check("d0_sel", 32'(digit_sel), 32'b0001); check("d0_seg", 32'(segment_out), 32'b1100110); end
      if (j == 4)  check("blank_sel", 32'(digit_sel), 32'd0);
      if (j == 6)  begin check("d1_sel", 32'(digit_sel), 32'b0010); check("d1_seg", 32'(segment_out), 32'b1001111); end
      if (j == 12) begin check("d2_sel", 32'(digit_sel), 32'b0100); check("d2_seg", 32'(segment_out), 32'b1011011); end
      if (j == 18) begin check("d3_sel", 32'(digit_sel), 32'b1000); check("d3_seg", 32'(segment_out), 32'b0000110); end
      if (j == 22) check("fd_early", 32'(frame_done), 32'd0);
      if (j == 23) check("fd_pulse", 32'(frame_done), 32'd1);
    end

    // Two loads inside one frame: the latest wins, and only from the next frame on.
    for (int j = 0; j < FRAME; j++) begin
      if (j == 4) begin load = 1'b1; bcd_in = 16'h5678; end
      if (j == 8) begin load = 1'b1; bcd_in = 16'h9999; end
      tick();
      if (j == 18) check("old_word_kept", 32'(segment_out), 32'b0000110);
    end
    tick();
    check("new_word_d0", 32'(segment_out), 32'b1101111);

    // Out-of-range nibble shows 'F'.
    load = 1'b1; bcd_in = 16'h00C0;
    tick();
    to_frame_start();
    for (int j = 0; j < FRAME; j++) begin
      tick();
      if (j == 6) check("nibble_f", 32'(segment_out), 32'b1110001);
      if (j == 0) check("zero_d0", 32'(segment_out), 32'b0111111);
    end

    // Drop en mid-frame, then restart at digit 0 with a full dwell.
    for (int j = 0; j < 8; j++) tick();
    en = 1'b0;
    tick();
    check("drop_sel", 32'(digit_sel), 32'd0);
    check("drop_seg", 32'(segment_out), 32'd0);
    tick();
    en = 1'b1;
    tick();
    for (int j = 0; j < FRAME; j++) begin
      tick();
      if (j < DW) check("restart_dwell", 32'(digit_sel), 32'b0001);
      if (j == DW) check("restart_blank", 32'(digit_sel), 32'd0);
      if (j == FRAME - 1) check("restart_fd", 32'(frame_done), 32'd1);
    end

`ifdef LEADING_ZERO_BLANK_EN
    load = 1'b1; bcd_in = 16'h0070;
    tick();
    to_frame_start();
    for (int j = 0; j < FRAME; j++) begin
      tick();
      if (j == 0)  check("lz_d0", 32'(segment_out), 32'b0111111);
      if (j == 6)  check("lz_d1", 32'(segment_out), 32'b0000111);
      if (j == 12) check("lz_d2", 32'(segment_out), 32'd0);
      if (j == 18) begin check("lz_d3", 32'(segment_out), 32'd0); check("lz_d3_sel", 32'(digit_sel), 32'b1000); end
    end
    load = 1'b1; bcd_in = 16'h0000;
    tick();
    to_frame_start();
    for (int j = 0; j < FRAME; j++) begin
      tick();
      if (j == 0) check("lz0_d0", 32'(segment_out), 32'b0111111);
      if (j == 6) check("lz0_d1", 32'(segment_out), 32'd0);
    end
`endif

    // Randomised traffic: enable dropouts, loads at arbitrary points, out-of-range nibbles.
    for (int j = 0; j < 1500; j++) begin
      en = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 11) == 0) begin
        load   = 1'b1;
        bcd_in = 16'($urandom);
        if ($urandom_range(0, 3) == 0) bcd_in[15:8] = 8'h00;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
